ssd_scan_decoder: RTL and testbench

- Reverse path of the hex-to-seven-segment encoder: watches a time-multiplexed 4-digit display bus (segments plus active-low anodes) and recovers the displayed hex digits and the overflow indication.
- Sits beside the display driver as a readback monitor, for self-check in the 4-bit processor and for on-board debug.
- Debounces each digit dwell, assembles a 4-digit frame, and classifies the frame as numeric, overflow ("ovfL") or erroneous.

---
 rtl/ssd_scan_decoder.sv | 112 +++++++++++
 tb/tb_ssd_scan_decoder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: readback monitor for a multiplexed 4-digit seven-segment bus.
// Recovers the displayed hex digits and the overflow ("ovfL") indication.
// Ports: clk, reset (sync, active-high); seg[6:0] (bit0=a..bit6=g, active-high);
//        an[3:0] (active-low, an[3] leftmost); hex_digits[15:0] ([15:12]=digit3);
//        is_overflow, decode_err (last frame status); frame_valid (1-cycle update pulse).
module ssd_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] hex_digits,
    output logic        is_overflow,
    output logic        decode_err,
    output logic        frame_valid
);
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

    logic [3:0]       s_an, p_an, sel, seen, bad;
    logic [6:0]       s_seg, p_seg;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cap, valid, same, capture, ovf;
    logic [3:0][6:0]  raw;
    logic [15:0]      num;

    function automatic logic [4:0] dec7(input logic [6:0] p);
        case (p)
            7'h3f: return 5'h00;
            7'h06: return 5'h01;
            7'h5b: return 5'h02;
            7'h4f: return 5'h03;
            7'h66: return 5'h04;
            7'h6d: return 5'h05;
            7'h7d: return 5'h06;
            7'h07: return 5'h07;
            7'h7f: return 5'h08;
            7'h67: return 5'h09;
            7'h77: return 5'h0a;
            7'h7c: return 5'h0b;
            7'h39: return 5'h0c;
            7'h5e: return 5'h0d;
            7'h79: return 5'h0e;
            7'h71: return 5'h0f;
            default: return 5'h10;
        endcase
    endfunction

    // sel is the one-hot digit position; a sample is valid only with exactly one anode low
    assign sel     = ~s_an;
    assign valid   = $onehot(sel);
    assign same    = valid && s_an == p_an && s_seg == p_seg;
    assign cnt_nxt = !valid ? '0 : same ? (cnt == STABLE ? cnt : cnt + CNT_W'(1)) : CNT_W'(1);
    // a fresh run starts uncaptured even if the previous run was captured
    assign capture = valid && cnt_nxt == STABLE && !(same && cap);

    always_ff @(posedge clk) begin
        if (reset) begin
            s_an  <= '0;
            s_seg <= '0;
            p_an  <= '0;
            p_seg <= '0;
            cnt   <= '0;
            cap   <= 1'b0;
        end else begin
            s_an  <= an;
            s_seg <= seg;
            p_an  <= s_an;
            p_seg <= s_seg;
            cnt   <= cnt_nxt;
            cap   <= capture || (same && cap);
        end
    end

    // a completed frame clears seen, but a capture on that same edge starts the next frame
    always_ff @(posedge clk) begin
        if (reset) begin
            raw  <= '0;
            seen <= '0;
        end else begin
            seen <= (seen == 4'hf ? 4'h0 : seen) | (capture ? sel : 4'h0);
            for (int i = 0; i < 4; i++)
                if (capture && sel[i]) raw[i] <= s_seg;
        end
    end

    assign ovf = raw == {7'h3f, 7'h1c, 7'h71, 7'h38};

    always_comb begin
        num = '0;
        bad = '0;
        for (int i = 0; i < 4; i++)
            {bad[i], num[4*i +: 4]} = dec7(raw[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_digits  <= '0;
            is_overflow <= 1'b0;
            decode_err  <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= seen == 4'hf;
            if (seen == 4'hf) begin
                hex_digits  <= ovf ? 16'habcd : num;
                is_overflow <= ovf;
                decode_err  <= !ovf && |bad;
            end
        end
    end
endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder: directed self-checking bench for ssd_scan_decoder.
module tb_ssd_scan_decoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg = '0;
    logic [3:0]  an = 4'hf;
    logic [15:0] hex_digits;
    logic        is_overflow, decode_err, frame_valid;
    int          checks = 0, failures = 0, fv_cnt = 0;

    ssd_scan_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .seg(seg), .an(an),
        .hex_digits(hex_digits), .is_overflow(is_overflow),
        .decode_err(decode_err), .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_valid) fv_cnt++;

    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] s3, s2, s1, s0);
        dwell(4'b0111, s3, 6);
        dwell(4'b1011, s2, 6);
        dwell(4'b1101, s1, 6);
        dwell(4'b1110, s0, 6);
        dwell(4'b1111, 7'h00, 4);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (hex_digits !== 16'h0) begin failures++; $display("FAIL reset_hex got=%h exp=0000", hex_digits); end
        checks++; if (is_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", is_overflow); end
        checks++; if (decode_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", decode_err); end
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_numeric;
        int base = fv_cnt;
        scan(7'h06, 7'h5b, 7'h4f, 7'h66);
        checks++; if (fv_cnt - base !== 1) begin failures++; $display("FAIL num_pulses got=%0d exp=1", fv_cnt - base); end
        checks++; if (hex_digits !== 16'h1234) begin failures++; $display("FAIL num_hex got=%h exp=1234", hex_digits); end
        checks++; if (is_overflow !== 1'b0) begin failures++; $display("FAIL num_ovf got=%b exp=0", is_overflow); end
        checks++; if (decode_err !== 1'b0) begin failures++; $display("FAIL num_err got=%b exp=0", decode_err); end
    endtask

    task automatic test_overflow;
        int base = fv_cnt;
        scan(7'h3f, 7'h1c, 7'h71, 7'h38);
        checks++; if (fv_cnt - base !== 1) begin failures++; $display("FAIL ovf_pulses got=%0d exp=1", fv_cnt - base); end
        checks++; if (hex_digits !== 16'habcd) begin failures++; $display("FAIL ovf_hex got=%h exp=abcd", hex_digits); end
        checks++; if (is_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", is_overflow); end
        checks++; if (decode_err !== 1'b0) begin failures++; $display("FAIL ovf_err got=%b exp=0", decode_err); end
        scan(7'h3f, 7'h3f, 7'h3f, 7'h3f);
        checks++; if (fv_cnt - base !== 2) begin failures++; $display("FAIL zero_pulses got=%0d exp=2", fv_cnt - base); end
        checks++; if (hex_digits !== 16'h0000) begin failures++; $display("FAIL zero_hex got=%h exp=0000", hex_digits); end
        checks++; if (is_overflow !== 1'b0) begin failures++; $display("FAIL zero_ovf got=%b exp=0", is_overflow); end
    endtask

    task automatic test_short_dwell;
        int base = fv_cnt;
        dwell(4'b0111, 7'h06, 6);
        dwell(4'b1011, 7'h5b, 3);
        dwell(4'b1101, 7'h4f, 6);
        dwell(4'b1110, 7'h66, 6);
        dwell(4'b1111, 7'h00, 4);
        checks++; if (fv_cnt - base !== 0) begin failures++; $display("FAIL short_nopulse got=%0d exp=0", fv_cnt - base); end
        checks++; if (hex_digits !== 16'h0000) begin failures++; $display("FAIL short_hold got=%h exp=0000", hex_digits); end
        dwell(4'b1011, 7'h5b, 6);
        dwell(4'b1111, 7'h00, 4);
        checks++; if (fv_cnt - base !== 1) begin failures++; $display("FAIL short_pulse got=%0d exp=1", fv_cnt - base); end
        checks++; if (hex_digits !== 16'h1234) begin failures++; $display("FAIL short_hex got=%h exp=1234", hex_digits); end
    endtask

    task automatic test_blank;
        int base = fv_cnt;
        scan(7'h79, 7'h71, 7'h00, 7'h3f);
        checks++; if (fv_cnt - base !== 1) begin failures++; $display("FAIL blank_pulses got=%0d exp=1", fv_cnt - base); end
        checks++; if (hex_digits !== 16'hef00) begin failures++; $display("FAIL blank_hex got=%h exp=ef00", hex_digits); end
        checks++; if (decode_err !== 1'b1) begin failures++; $display("FAIL blank_err got=%b exp=1", decode_err); end
        checks++; if (is_overflow !== 1'b0) begin failures++; $display("FAIL blank_ovf got=%b exp=0", is_overflow); end
    endtask

    task automatic test_glitch;
        int base = fv_cnt;
        dwell(4'b0111, 7'h06, 3);
        dwell(4'b1001, 7'h06, 1);
        dwell(4'b0111, 7'h06, 3);
        dwell(4'b1011, 7'h5b, 6);
        dwell(4'b1101, 7'h4f, 6);
        dwell(4'b1110, 7'h66, 6);
        dwell(4'b1111, 7'h00, 4);
        checks++; if (fv_cnt - base !== 0) begin failures++; $display("FAIL glitch_nopulse got=%0d exp=0", fv_cnt - base); end
        dwell(4'b0111, 7'h7d, 20);
        dwell(4'b1111, 7'h00, 4);
        checks++; if (fv_cnt - base !== 1) begin failures++; $display("FAIL long_pulse got=%0d exp=1", fv_cnt - base); end
        checks++; if (hex_digits !== 16'h6234) begin failures++; $display("FAIL long_hex got=%h exp=6234", hex_digits); end
        dwell(4'b1011, 7'h5b, 6);
        dwell(4'b1101, 7'h4f, 6);
        dwell(4'b1110, 7'h66, 6);
        dwell(4'b1111, 7'h00, 4);
        checks++; if (fv_cnt - base !== 1) begin failures++; $display("FAIL long_single got=%0d exp=1", fv_cnt - base); end
    endtask

    task automatic test_reset_mid;
        int base = fv_cnt;
        dwell(4'b1011, 7'h06, 6);
        dwell(4'b1101, 7'h06, 6);
        dwell(4'b1110, 7'h06, 6);
        dwell(4'b1111, 7'h00, 2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (hex_digits !== 16'h0) begin failures++; $display("FAIL mid_hex got=%h exp=0000", hex_digits); end
        checks++; if (is_overflow !== 1'b0 || decode_err !== 1'b0 || frame_valid !== 1'b0) begin failures++; $display("FAIL mid_flags got=%b%b%b exp=000", is_overflow, decode_err, frame_valid); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (hex_digits !== 16'h0 || is_overflow !== 1'b0 || decode_err !== 1'b0 || frame_valid !== 1'b0) begin failures++; $display("FAIL post_reset got=%h/%b%b%b exp=0000/000", hex_digits, is_overflow, decode_err, frame_valid); end
        checks++; if (fv_cnt - base !== 0) begin failures++; $display("FAIL mid_nopulse got=%0d exp=0", fv_cnt - base); end
        scan(7'h7f, 7'h67, 7'h77, 7'h7c);
        checks++; if (fv_cnt - base !== 1) begin failures++; $display("FAIL after_pulses got=%0d exp=1", fv_cnt - base); end
        checks++; if (hex_digits !== 16'h89ab) begin failures++; $display("FAIL after_hex got=%h exp=89ab", hex_digits); end
        checks++; if (is_overflow !== 1'b0 || decode_err !== 1'b0) begin failures++; $display("FAIL after_flags got=%b%b exp=00", is_overflow, decode_err); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_numeric;
        test_overflow;
        test_short_dwell;
        test_blank;
        test_glitch;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
